// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: shared FSM state type and load/store funct3 encodings for dmem_responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// dmem_lane_align: combinational byte-lane steering -- store byte-enables and
// replicated write data, load lane extract with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rword[{lane, 3'b000} +: 8];
    half_v   = rword[{lane[1], 4'b0000} +: 16];
    be       = 4'b0000;
    wdata_sh = '0;
    rdata    = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << lane;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << {lane[1], 1'b0};
        wdata_sh = {2{wdata[15:0]}};
        rdata    = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: fixed-latency data-memory responder with a word-organised store.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of aligning them down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  lane;
  logic        align_err, f3_err, range_err, acc_err;
  logic [IDX_W-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata_sh, load_data;
  logic        go_resp, commit;

  // In IDLE the access is decoded straight from the request so LATENCY=1 can commit on the accept edge.
  always_comb begin
    acc_we    = (state_q == IDLE) ? req_we     : we_q;
    acc_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    acc_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    lane      = acc_addr[1:0];
    align_err = (((acc_f3 == F3_H) || (acc_f3 == F3_HU)) && acc_addr[0]) ||
                ((acc_f3 == F3_W) && (acc_addr[1:0] != 2'b00));
`else
    if (acc_f3 == F3_W)                            lane = 2'b00;
    else if ((acc_f3 == F3_H) || (acc_f3 == F3_HU)) lane = {acc_addr[1], 1'b0};
    else                                           lane = acc_addr[1:0];
    align_err = 1'b0;
`endif
    f3_err    = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111) ||
                (acc_we && !((acc_f3 == F3_B) || (acc_f3 == F3_H) || (acc_f3 == F3_W)));
    range_err = ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_err   = f3_err || range_err || align_err;
    idx       = acc_addr[IDX_W+1:2];
  end

  dmem_lane_align u_align (
    .funct3   (acc_f3),
    .lane     (lane),
    .wdata    (acc_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    go_resp      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      state_d      = RESP;
      cnt_d        = 4'd0;
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      resp_rdata_d = (acc_err || acc_we) ? 32'd0 : load_data;
    end
    req_ready_d = (state_d == IDLE);
    // Reset must block the commit even when a LATENCY=1 request sits on the inputs.
    commit      = go_resp && acc_we && !acc_err && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder: directed load/store vectors with a scoreboard queue and a decoupled response monitor.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   in_resp = 0;
  logic [31:0] held_d;
  logic        held_e;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout, expected DUT event", nm);
  endtask

  // Monitor: the first cycle of each response is scored; later cycles must hold still.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (!in_resp) begin
        exp_t e;
        in_resp = 1;
        held_d  = resp_rdata;
        held_e  = resp_err;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata=%h err=%b, expected no response", resp_rdata, resp_err);
        end else begin
          e = sb.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(LATENCY));
        end
      end else begin
        check("hold_rdata", resp_rdata, held_d);
        check("hold_err", {31'b0, resp_err}, {31'b0, held_e});
      end
    end else begin
      in_resp = 0;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input bit expect_resp);
    int tries = 0;
    while (!req_ready && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!req_ready) begin
      fail_now({nm, "_ready"});
      return;
    end
    req_valid  = 1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (expect_resp) sb.push_back('{exp_d, exp_e, cyc, nm});
    @(posedge clk); #1;
    req_valid  = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || resp_valid) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0 || resp_valid) fail_now("drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 0; resp_ready = 1; req_valid = 0; req_we = 0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1;
    @(posedge clk); #1;

    issue("sw_10",  1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    issue("lw_10",  0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    issue("lb_13",  0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 0, 1);
    issue("lbu_13", 0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 0, 1);
    issue("lh_12",  0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 0, 1);
    issue("lhu_10", 0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 0, 1);
    issue("sb_11",  1, F3_B,  32'h11, 32'hABCDEF55, 32'h0, 0, 1);
    issue("lw_10b", 0, F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 0, 1);
    issue("sw_14",  1, F3_W,  32'h14, 32'h00000000, 32'h0, 0, 1);
    issue("sh_16",  1, F3_H,  32'h16, 32'hFFFF8001, 32'h0, 0, 1);
    issue("lw_14",  0, F3_W,  32'h14, 32'h0, 32'h80010000, 0, 1);
    issue("lh_16",  0, F3_H,  32'h16, 32'h0, 32'hFFFF8001, 0, 1);
    issue("lhu_16", 0, F3_HU, 32'h16, 32'h0, 32'h00008001, 0, 1);
    issue("lb_14",  0, F3_B,  32'h14, 32'h0, 32'h00000000, 0, 1);

    issue("lw_oob",   0, F3_W,   32'(4*DEPTH), 32'h0, 32'h0, 1, 1);
    issue("ld_f3_011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
    issue("st_f3_100", 1, F3_BU,  32'h10, 32'h0, 32'h0, 1, 1);
    issue("lw_10c",   0, F3_W,   32'h10, 32'h0, 32'hDEAD55EF, 0, 1);
    issue("sw_last",  1, F3_W,   32'(4*DEPTH-4), 32'hA5A5A5A5, 32'h0, 0, 1);
    issue("lw_last",  0, F3_W,   32'(4*DEPTH-4), 32'h0, 32'hA5A5A5A5, 0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue("lh_11", 0, F3_H, 32'h11, 32'h0, 32'h0, 1, 1);
    issue("lw_13", 0, F3_W, 32'h13, 32'h0, 32'h0, 1, 1);
`else
    issue("lh_11", 0, F3_H, 32'h11, 32'h0, 32'h000055EF, 0, 1);
    issue("lw_13", 0, F3_W, 32'h13, 32'h0, 32'hDEAD55EF, 0, 1);
`endif
    drain();

    // Backpressure: response must hold while resp_ready is low.
    resp_ready = 0;
    issue("lw_bp", 0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 0, 1);
    begin
      int t = 0;
      while (!resp_valid && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (!resp_valid) fail_now("bp_valid");
    end
    repeat (5) begin
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'b0, req_ready}, 32'd1);
    check("bp_release_valid", {31'b0, resp_valid}, 32'd0);

    // Reset during WAIT abandons the store.
    issue("sw_20", 1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 0, 1);
    issue("lw_20", 0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1);
    drain();
    issue("sw_20_abort", 1, F3_W, 32'h20, 32'h12345678, 32'h0, 0, 0);
    rst = 0;
    #1;
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    repeat (4) begin
      check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    issue("lw_20_after", 0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data store.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr  input  32  byte address; driven from the register file's addr2Mem.
REQ-010 SHALL have port req_wdata  input  32  store data, LSB-aligned; driven from the register file's data2Mem.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load result, extended to 32 bits; feeds the register file's dataFromMem.
REQ-014 SHALL have port resp_err  output  1  request faulted (size, range or alignment).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a clk edge with req_valid && req_ready, latching we, funct3, addr and wdata.
REQ-017 SHALL enter WAIT on accept when LATENCY > 1 and hold WAIT for LATENCY-1 cycles on a down-counter; it SHALL go directly to RESP when LATENCY = 1.
REQ-018 SHALL assert resp_valid exactly LATENCY edges after the accepting edge, and hold resp_valid, resp_rdata and resp_err stable until resp_ready.
REQ-019 SHALL return to IDLE on the edge with resp_valid && resp_ready; no new request is accepted on that same edge.
REQ-020 Loads: B and H SHALL sign-extend, BU and HU SHALL zero-extend, and W SHALL pass through. Byte lane = addr[1:0]; half lane = addr[1].
REQ-021 Stores SHALL write only the addressed byte lanes (B: 1 lane, H: 2 lanes, W: 4 lanes), with the write committed on the edge entering RESP; resp_rdata = 0 for stores.
REQ-022 SHALL flag resp_err for these requests, with no write and resp_rdata = 0: funct3 values 011, 110 or 111; store funct3 other than 000, 001 or 010; or addr[31:2] >= DEPTH_WORDS.
REQ-023 Each request SHALL still receive exactly one response after LATENCY cycles, including faulted requests.

Reset
REQ-024 On rst low: state IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 1.
REQ-025 Reset mid-request SHALL abandon the request: no write is performed if reset asserts before the commit edge, and no response is issued.
REQ-026 Data store contents SHALL NOT be reset.

Configuration
REQ-027 With DMEM_MISALIGN_TRAP_EN defined, these requests SHALL fault per REQ-022: H/HU with addr[0] = 1, and W with addr[1:0] != 0.
REQ-028 Without DMEM_MISALIGN_TRAP_EN, these low address bits SHALL be forced to 0 before access (H: addr[0]; W: addr[1:0]), and no alignment error SHALL be raised.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state enum and the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-030 Sub-module dmem_lane_align SHALL be purely combinational and generate store byte-enables, shifted write data, and load extract/extend.

Verification
REQ-031 Reset, LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid 2 cycles after each accept; load rdata 0xDEADBEEF, err 0.
REQ-032 After REQ-031: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; other lanes unchanged.
REQ-034 Response backpressure: resp_ready held low 5 cycles -> resp_valid and rdata stable; req_ready 0 throughout; on release, IDLE and req_ready 1 the next cycle.
REQ-035 Fault cases: LW addr 4*DEPTH_WORDS -> err 1, rdata 0; funct3 011 -> err 1. With DMEM_MISALIGN_TRAP_EN, LH 0x11 -> err 1; without it, LH 0x11 reads the half at 0x10.
REQ-036 rst low for one cycle during WAIT of SW 0x20 data 0x12345678 -> no response; a subsequent LW 0x20 returns the prior contents.
